// File: rtl/fifo_null_pages_pkg.sv
// Shared page-addressing definitions for the packet SRAM bookkeeping logic.
package fifo_null_pages_pkg;

    localparam int PAGE_ADDR_WIDTH = 11;
    localparam int NUM_PAGES       = 2047;

    typedef logic [PAGE_ADDR_WIDTH-1:0] page_addr_t;

endpackage

// File: rtl/page_ring_buffer.sv
// Generic circular buffer: asynchronous head read, synchronous write, occupancy count.
module page_ring_buffer #(
    parameter int WIDTH      = 11,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok   = push && (count != FULL_COUNT);
    assign pop_ok    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fifo_null_pages.sv
// Free-page allocator: serves never-used pages from a counter, then recycled pages FIFO.
module fifo_null_pages
    import fifo_null_pages_pkg::*;
#(
    parameter int ADDR_WIDTH = PAGE_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** PAGE_ADDR_WIDTH,
    parameter int NUM_PAGES  = fifo_null_pages_pkg::NUM_PAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pop_head,
    output logic [ADDR_WIDTH-1:0] head_addr,
    input  logic                  push_tail,
    input  logic [ADDR_WIDTH-1:0] tail_addr,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   free_count
);

    localparam logic [ADDR_WIDTH:0] PAGE_LIMIT = (ADDR_WIDTH+1)'(NUM_PAGES);

    logic [ADDR_WIDTH:0]   fresh_ptr;
    logic [ADDR_WIDTH:0]   q_count;
    logic [ADDR_WIDTH-1:0] q_head;
    logic                  fresh_avail;
    logic                  q_pop;

    assign fresh_avail = fresh_ptr < PAGE_LIMIT;
    assign free_count  = (PAGE_LIMIT - fresh_ptr) + q_count;
    assign empty       = (free_count == '0);
    // Queue is only drained once the fresh range is used up.
    assign q_pop       = pop_head && !empty && !fresh_avail;

    always_comb begin
        head_addr = '0;
        if (!empty) begin
            if (fresh_avail) head_addr = fresh_ptr[ADDR_WIDTH-1:0];
            else             head_addr = q_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fresh_ptr <= '0;
        end else if (pop_head && fresh_avail) begin
            fresh_ptr <= fresh_ptr + 1'b1;
        end
    end

    page_ring_buffer #(
        .WIDTH      (ADDR_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst_n),
        .push      (push_tail),
        .push_data (tail_addr),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fifo_null_pages.sv
// Directed bench for the free-page allocator with hand-computed expectations.
module tb_fifo_null_pages;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pop_head = 1'b0;
    logic        push_tail = 1'b0;
    logic [10:0] tail_addr = '0;
    logic [10:0] head_addr;
    logic        empty;
    logic [11:0] free_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    fifo_null_pages #(
        .ADDR_WIDTH (11),
        .DEPTH      (2048),
        .NUM_PAGES  (2047)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pop_head   (pop_head),
        .head_addr  (head_addr),
        .push_tail  (push_tail),
        .tail_addr  (tail_addr),
        .empty      (empty),
        .free_count (free_count)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int unsigned head, input int unsigned fc, input logic emp);
        check_vec({tag, ".head"}, 32'(head_addr), 32'(head));
        check_vec({tag, ".free"}, 32'(free_count), 32'(fc));
        check_vec({tag, ".empty"}, 32'(empty), 32'(emp));
    endtask

    // One clock with the given controls; outputs are settled 1ns after the edge.
    task automatic step(input logic rst, input logic pop, input logic push, input logic [10:0] addr);
        rst_n     = rst;
        pop_head  = pop;
        push_tail = push;
        tail_addr = addr;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        pop_head  = 1'b0;
        push_tail = 1'b0;
        tail_addr = '0;
    endtask

    initial begin
        #2;
        // Reset state
        step(1'b1, 1'b0, 1'b0, 11'd0);
        check_state("reset", 0, 2047, 1'b0);

        // Three pops from the fresh range, then a push that must not disturb head
        repeat (3) step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("pop3", 3, 2044, 1'b0);
        step(1'b0, 1'b0, 1'b1, 11'd1);
        check_state("push1", 3, 2045, 1'b0);

        // Drain every fresh page
        step(1'b1, 1'b0, 1'b0, 11'd0);
        repeat (2046) step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("last_fresh", 2046, 1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("exhausted", 0, 0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("pop_empty", 0, 0, 1'b1);

        // Recycled pages served in FIFO order
        step(1'b0, 1'b0, 1'b1, 11'd7);
        check_state("push7", 7, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 11'd2);
        check_state("push2", 7, 2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("pop7", 2, 1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("pop2", 0, 0, 1'b1);

        // Simultaneous push/pop with fresh pages left
        step(1'b1, 1'b0, 1'b0, 11'd0);
        step(1'b0, 1'b1, 1'b1, 11'd5);
        check_state("pp_fresh", 1, 2047, 1'b0);
        repeat (2046) step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("q_head5", 5, 1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("drained", 0, 0, 1'b1);
        // Simultaneous push/pop while empty: pop ignored, no bypass
        step(1'b0, 1'b1, 1'b1, 11'd9);
        check_state("pp_empty", 9, 1, 1'b0);

        // Queue full boundary: 2048 pushes accepted, the next one dropped
        step(1'b1, 1'b0, 1'b0, 11'd0);
        for (int unsigned i = 0; i < 2048; i++) step(1'b0, 1'b0, 1'b1, 11'((i + 100) % 2048));
        check_state("q_full", 0, 4095, 1'b0);
        step(1'b0, 1'b0, 1'b1, 11'd1234);
        check_state("q_overflow", 0, 4095, 1'b0);
        repeat (2047) step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("q_first", 100, 2048, 1'b0);
        step(1'b0, 1'b1, 1'b0, 11'd0);
        check_state("q_second", 101, 2047, 1'b0);

        // Reset mid-operation, with push/pop requested in the reset cycle
        step(1'b1, 1'b0, 1'b0, 11'd0);
        repeat (100) step(1'b0, 1'b1, 1'b0, 11'd0);
        for (int unsigned i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 11'(i + 1));
        check_state("pre_reset", 100, 1957, 1'b0);
        step(1'b1, 1'b1, 1'b1, 11'd33);
        check_state("mid_reset", 0, 2047, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
